// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a/b on start, adds one bit per clock LSB-first,
// then publishes sum/cout together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bit_s;
  logic             carry_next;
  logic [WIDTH-1:0] res_shifted;

  assign bit_s       = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_next  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign res_shifted = {bit_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shifted;
        carry_d = carry_next;
        cnt_d   = cnt_q + 1'b1;
        // Final bit: publish the whole result at once so no partial sum leaks out.
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          sum_d   = res_shifted;
          cout_d  = carry_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, hand-written
// corner sequences and random operands against an arithmetic reference.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;
  logic [W-1:0] exp_sum_held;
  logic         exp_cout_held;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vsum;
    logic         vcout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // One complete operation: start pulse, W busy cycles with held outputs,
  // one done cycle with the new result, then idle.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = ~xa; b = ~xb;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("sum_hold", sum, exp_sum_held);
      check("cout_hold", cout, exp_cout_held);
    end
    @(negedge clk);
    check("busy_done", busy, 1'b0);
    check("done_pulse", done, 1'b1);
    check("sum", sum, es);
    check("cout", cout, ec);
    exp_sum_held = es; exp_cout_held = ec;
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    $display("op a=%02h b=%02h sum=%02h cout=%0b (exp %02h/%0b)", xa, xb, sum, cout, es, ec);
  endtask

  vec_t vecs [6];

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rr;
    int           dones;

    checks = 0; errors = 0;
    exp_sum_held = '0; exp_cout_held = 1'b0;
    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsum, vecs[i].vcout);

    // Asynchronous reset between edges clears outputs immediately.
    run_op(8'hFF, 8'h01, 8'h00, 1'b1);
    run_op(8'hF0, 8'h0F, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", sum, '0);
    check("arst_cout", cout, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_sum_held = '0; exp_cout_held = 1'b0;

    // Back-to-back with start held high; operands changed during RUN.
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      a = 8'h00; b = 8'h00;
      check("b2b_busy1", busy, 1'b1);
      check("b2b_hold1", sum, 8'h00);
    end
    @(negedge clk);
    check("b2b_done1", done, 1'b1);
    check("b2b_sum1", sum, 8'hFE);
    check("b2b_cout1", cout, 1'b1);
    @(negedge clk);
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_done", done, 1'b0);
    @(negedge clk);
    check("b2b_accept2", busy, 1'b1);
    start = 1'b0;
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      check("b2b_busy2", busy, 1'b1);
      check("b2b_hold2", sum, 8'hFE);
    end
    @(negedge clk);
    check("b2b_done2", done, 1'b1);
    check("b2b_sum2", sum, 8'h00);
    check("b2b_cout2", cout, 1'b0);
    $display("b2b ops FF+FF then 00+00 second sum=%02h cout=%0b", sum, cout);

    // Start pulse with new operands during RUN is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 3) start = 1'b0;
      if (done) dones++;
      @(negedge clk);
    end
    check("ign_dones", dones, 1);
    check("ign_sum", sum, 8'h96);
    check("ign_cout", cout, 1'b0);
    check("ign_busy", busy, 1'b0);
    $display("ignore-start op sum=%02h cout=%0b dones=%0d", sum, cout, dones);
    exp_sum_held = 8'h96; exp_cout_held = 1'b0;

    // Reset after the 4th RUN edge aborts; start ignored while in reset.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_ign_start", busy, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);
    exp_sum_held = '0; exp_cout_held = 1'b0;
    run_op(8'h12, 8'h34, 8'h46, 1'b0);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rr = ref_add(ra, rb);
      run_op(ra, rb, rr[W-1:0], rr[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
